// File: rtl/fir_frame_arbiter.sv
// fir_frame_arbiter: shares one fir engine between two AXI-Stream requesters.
// Each granted frame is programmed over AXI-Lite (length, then ap_start),
// streamed through combinationally, and released once ap_done is polled.
module fir_frame_arbiter #(
    parameter int unsigned pADDR_WIDTH = 12,
    parameter int unsigned pDATA_WIDTH = 32,
    parameter int unsigned pLEN_WIDTH  = 10
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    // requester 0 / 1 X streams
    input  logic                   s0_tvalid,
    input  logic [pDATA_WIDTH-1:0] s0_tdata,
    input  logic                   s0_tlast,
    output logic                   s0_tready,
    input  logic                   s1_tvalid,
    input  logic [pDATA_WIDTH-1:0] s1_tdata,
    input  logic                   s1_tlast,
    output logic                   s1_tready,
    // requester 0 / 1 Y streams
    output logic                   m0_tvalid,
    output logic [pDATA_WIDTH-1:0] m0_tdata,
    output logic                   m0_tlast,
    input  logic                   m0_tready,
    output logic                   m1_tvalid,
    output logic [pDATA_WIDTH-1:0] m1_tdata,
    output logic                   m1_tlast,
    input  logic                   m1_tready,
    input  logic [pLEN_WIDTH-1:0]  len0,
    input  logic [pLEN_WIDTH-1:0]  len1,
    // AXI-Lite master
    output logic                   awvalid,
    output logic                   wvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   awready,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   rready,
    // engine stream ports
    output logic                   fir_ss_tvalid,
    output logic [pDATA_WIDTH-1:0] fir_ss_tdata,
    output logic                   fir_ss_tlast,
    input  logic                   fir_ss_tready,
    input  logic                   fir_sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] fir_sm_tdata,
    input  logic                   fir_sm_tlast,
    output logic                   fir_sm_tready,
    output logic                   busy,
    output logic                   owner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LEN,
        S_WR_START,
        S_STREAM,
        S_POLL_AR,
        S_POLL_R
    } state_t;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'('h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'('h10);

    state_t                  state_q;
    logic                    owner_q;
    logic                    last_grant_q;
    logic [pLEN_WIDTH-1:0]   len_q;
    logic [pLEN_WIDTH-1:0]   in_cnt_q;
    logic                    in_done_q;
    logic                    awvalid_q;
    logic [pADDR_WIDTH-1:0]  awaddr_q;
    logic [pDATA_WIDTH-1:0]  wdata_q;
    logic                    arvalid_q;
    logic                    rready_q;

    logic                    grant_d;
    logic [pLEN_WIDTH-1:0]   len_sel_d;
    logic                    len_hit;
    logic                    x_hs;
    logic                    y_last_hs;
    logic                    rdata_unused;

    // Only the ap_done bit of the status word matters.
    assign rdata_unused = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};

    assign awvalid = awvalid_q;
    assign wvalid  = awvalid_q;
    assign awaddr  = awaddr_q;
    assign wdata   = wdata_q;
    assign arvalid = arvalid_q;
    assign araddr  = ADDR_CTRL;
    assign rready  = rready_q;
    assign busy    = (state_q != S_IDLE);
    assign owner   = owner_q;

    // Round-robin pick: alternate on ties, otherwise take whoever is asking.
    always_comb begin
        if (s0_tvalid && s1_tvalid) begin
            grant_d = ~last_grant_q;
        end else begin
            grant_d = s1_tvalid;
        end
        len_sel_d = grant_d ? len1 : len0;
    end

    // Combinational stream routing for the current owner; everything idles outside STREAM.
    always_comb begin
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        m0_tvalid     = 1'b0;
        m0_tdata      = '0;
        m0_tlast      = 1'b0;
        m1_tvalid     = 1'b0;
        m1_tdata      = '0;
        m1_tlast      = 1'b0;
        fir_ss_tvalid = 1'b0;
        fir_ss_tdata  = '0;
        fir_ss_tlast  = 1'b0;
        fir_sm_tready = 1'b0;
        len_hit       = (len_q != '0) && (in_cnt_q == len_q - pLEN_WIDTH'(1));
        if (state_q == S_STREAM) begin
            fir_ss_tvalid = (owner_q ? s1_tvalid : s0_tvalid) & ~in_done_q;
            fir_ss_tdata  = owner_q ? s1_tdata : s0_tdata;
            fir_ss_tlast  = (owner_q ? s1_tlast : s0_tlast) | len_hit;
            fir_sm_tready = owner_q ? m1_tready : m0_tready;
            if (owner_q) begin
                s1_tready = fir_ss_tready & ~in_done_q;
                m1_tvalid = fir_sm_tvalid;
                m1_tdata  = fir_sm_tdata;
                m1_tlast  = fir_sm_tlast;
            end else begin
                s0_tready = fir_ss_tready & ~in_done_q;
                m0_tvalid = fir_sm_tvalid;
                m0_tdata  = fir_sm_tdata;
                m0_tlast  = fir_sm_tlast;
            end
        end
    end

    assign x_hs      = fir_ss_tvalid & fir_ss_tready;
    assign y_last_hs = fir_sm_tvalid & fir_sm_tready & fir_sm_tlast;

    // Frame sequencer: grant, two AXI-Lite writes, stream, poll ap_done.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            len_q        <= '0;
            in_cnt_q     <= '0;
            in_done_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (s0_tvalid || s1_tvalid) begin
                        state_q      <= S_WR_LEN;
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        len_q        <= len_sel_d;
                        in_cnt_q     <= '0;
                        in_done_q    <= 1'b0;
                        awvalid_q    <= 1'b1;
                        awaddr_q     <= ADDR_LEN;
                        wdata_q      <= pDATA_WIDTH'(len_sel_d);
                    end
                end
                S_WR_LEN: begin
                    if (awvalid_q && awready && wready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= S_WR_START;
                    end
                end
                S_WR_START: begin
                    // Entered with valid low, which gives the idle cycle between writes.
                    if (!awvalid_q) begin
                        awvalid_q <= 1'b1;
                        awaddr_q  <= ADDR_CTRL;
                        wdata_q   <= pDATA_WIDTH'(1);
                    end else if (awready && wready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (x_hs) begin
                        in_cnt_q <= in_cnt_q + pLEN_WIDTH'(1);
                        if (fir_ss_tlast) begin
                            in_done_q <= 1'b1;
                        end
                    end
                    if (y_last_hs) begin
                        state_q   <= S_POLL_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                S_POLL_AR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_POLL_R;
                    end
                end
                S_POLL_R: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        if (rdata[1]) begin
                            state_q <= S_IDLE;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_POLL_AR;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_frame_arbiter.sv
// Directed bench for fir_frame_arbiter: the bench plays both requesters,
// the AXI-Lite slave and the fir engine stream ports.
module tb_fir_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s0_tvalid = 0, s0_tlast = 0, s1_tvalid = 0, s1_tlast = 0;
    logic [31:0] s0_tdata = 0, s1_tdata = 0;
    logic        s0_tready, s1_tready;
    logic        m0_tvalid, m0_tlast, m1_tvalid, m1_tlast;
    logic [31:0] m0_tdata, m1_tdata;
    logic        m0_tready = 0, m1_tready = 0;
    logic [9:0]  len0 = 0, len1 = 0;
    logic        awvalid, wvalid, arvalid, rready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata;
    logic        awready = 0, wready = 0, arready = 0, rvalid = 0;
    logic [31:0] rdata = 0;
    logic        fir_ss_tvalid, fir_ss_tlast, fir_sm_tready;
    logic [31:0] fir_ss_tdata;
    logic        fir_ss_tready = 0;
    logic        fir_sm_tvalid = 0, fir_sm_tlast = 0;
    logic [31:0] fir_sm_tdata = 0;
    logic        busy, owner;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        rdy;
        logic        e_ssv;
        logic        e_ssl;
        logic        e_str;
    } vec_t;
    vec_t tbl[8];

    fir_frame_arbiter #(
        .pADDR_WIDTH(12),
        .pDATA_WIDTH(32),
        .pLEN_WIDTH (10)
    ) dut (
        .axis_clk(clk), .axis_rst(rst),
        .s0_tvalid(s0_tvalid), .s0_tdata(s0_tdata), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tvalid(s1_tvalid), .s1_tdata(s1_tdata), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m0_tvalid(m0_tvalid), .m0_tdata(m0_tdata), .m0_tlast(m0_tlast), .m0_tready(m0_tready),
        .m1_tvalid(m1_tvalid), .m1_tdata(m1_tdata), .m1_tlast(m1_tlast), .m1_tready(m1_tready),
        .len0(len0), .len1(len1),
        .awvalid(awvalid), .wvalid(wvalid), .awaddr(awaddr), .wdata(wdata),
        .awready(awready), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready),
        .fir_ss_tvalid(fir_ss_tvalid), .fir_ss_tdata(fir_ss_tdata), .fir_ss_tlast(fir_ss_tlast),
        .fir_ss_tready(fir_ss_tready),
        .fir_sm_tvalid(fir_sm_tvalid), .fir_sm_tdata(fir_sm_tdata), .fir_sm_tlast(fir_sm_tlast),
        .fir_sm_tready(fir_sm_tready),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_s(input bit g, input logic v, input logic [31:0] d, input logic l);
        if (g) begin
            s1_tvalid = v; s1_tdata = d; s1_tlast = l;
        end else begin
            s0_tvalid = v; s0_tdata = d; s0_tlast = l;
        end
    endtask

    // One AXI-Lite write: bounded wait for valid, hold ready low for `delay`
    // cycles checking stability, then handshake and check the drop.
    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input int delay, input int max_wait);
        int n = 0;
        while (!awvalid && n < max_wait) begin
            @(negedge clk); #1; n++;
        end
        chk("awvalid_rise", awvalid, 1);
        chk("wvalid_rise", wvalid, 1);
        chk("awaddr", awaddr, a);
        chk("wdata", wdata, d);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk); #1;
            chk("awvalid_hold", awvalid, 1);
            chk("awaddr_stable", awaddr, a);
            chk("wdata_stable", wdata, d);
        end
        @(negedge clk); awready = 1; wready = 1; #1;
        @(negedge clk); awready = 0; wready = 0; #1;
        chk("awvalid_drop", awvalid, 0);
        chk("wvalid_drop", wvalid, 0);
    endtask

    task automatic send_x(input bit g, input int n, input int src_last, input int exp_last, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            set_s(g, 1'b1, base + i, i == src_last);
            fir_ss_tready = 1;
            #1;
            chk("ss_tvalid", fir_ss_tvalid, 1);
            chk("ss_tdata", fir_ss_tdata, base + i);
            chk("ss_tlast", fir_ss_tlast, i == exp_last);
            chk("s_tready", g ? s1_tready : s0_tready, 1);
            chk("other_s_tready", g ? s0_tready : s1_tready, 0);
            @(negedge clk);
        end
        set_s(g, 1'b0, 32'h0, 1'b0);
        fir_ss_tready = 0;
    endtask

    task automatic recv_y(input bit g, input int n, input bit toggle);
        int  i   = 0;
        int  cyc = 0;
        bit  rdy = !toggle;
        while (i < n && cyc < 4 * n + 4) begin
            fir_sm_tvalid = 1; fir_sm_tdata = 32'h200 + i; fir_sm_tlast = (i == n - 1);
            if (g) m1_tready = rdy; else m0_tready = rdy;
            #1;
            chk("m_tvalid", g ? m1_tvalid : m0_tvalid, 1);
            chk("m_tdata", g ? m1_tdata : m0_tdata, 32'h200 + i);
            chk("m_tlast", g ? m1_tlast : m0_tlast, i == n - 1);
            chk("other_m_tvalid", g ? m0_tvalid : m1_tvalid, 0);
            chk("fir_sm_tready", fir_sm_tready, rdy);
            @(negedge clk);
            if (rdy) i++;
            cyc++;
            if (toggle) rdy = !rdy;
        end
        chk("y_beat_count", i, n);
        fir_sm_tvalid = 0; fir_sm_tlast = 0; m0_tready = 0; m1_tready = 0;
        #1;
        chk("arvalid_after_y", arvalid, 1);
    endtask

    // n_retry reads returning retry_val, then one returning done_val.
    task automatic do_poll(input int n_retry, input logic [31:0] retry_val, input logic [31:0] done_val);
        int reads = 0;
        for (int k = 0; k <= n_retry; k++) begin
            chk("arvalid_poll", arvalid, 1);
            chk("araddr", araddr, 0);
            chk("busy_poll", busy, 1);
            arready = 1;
            @(negedge clk); arready = 0; #1;
            chk("arvalid_drop", arvalid, 0);
            chk("rready", rready, 1);
            rvalid = 1; rdata = (k == n_retry) ? done_val : retry_val;
            @(negedge clk); rvalid = 0; rdata = 0; #1;
            reads++;
            if (k == n_retry) begin
                chk("busy_done", busy, 0);
                chk("rready_drop", rready, 0);
            end else begin
                chk("arvalid_reissue", arvalid, 1);
            end
        end
        chk("read_count", reads, n_retry + 1);
    endtask

    initial begin
        // Forced-tlast vectors: owner 1, len_q = 3, source never asserts tlast.
        tbl[0] = '{v:1'b0, d:32'h300, l:1'b0, rdy:1'b1, e_ssv:1'b0, e_ssl:1'b0, e_str:1'b1};
        tbl[1] = '{v:1'b1, d:32'h300, l:1'b0, rdy:1'b1, e_ssv:1'b1, e_ssl:1'b0, e_str:1'b1};
        tbl[2] = '{v:1'b1, d:32'h301, l:1'b0, rdy:1'b0, e_ssv:1'b1, e_ssl:1'b0, e_str:1'b0};
        tbl[3] = '{v:1'b1, d:32'h301, l:1'b0, rdy:1'b1, e_ssv:1'b1, e_ssl:1'b0, e_str:1'b1};
        tbl[4] = '{v:1'b1, d:32'h302, l:1'b0, rdy:1'b1, e_ssv:1'b1, e_ssl:1'b1, e_str:1'b1};
        tbl[5] = '{v:1'b1, d:32'h303, l:1'b0, rdy:1'b1, e_ssv:1'b0, e_ssl:1'b0, e_str:1'b0};
        tbl[6] = '{v:1'b1, d:32'h304, l:1'b0, rdy:1'b1, e_ssv:1'b0, e_ssl:1'b0, e_str:1'b0};
        tbl[7] = '{v:1'b1, d:32'h305, l:1'b0, rdy:1'b1, e_ssv:1'b0, e_ssl:1'b0, e_str:1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 0; #1;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_ss_tvalid", fir_ss_tvalid, 0);
        chk("rst_m0_tvalid", m0_tvalid, 0);

        // Frame A: simultaneous requests, requester 0 wins, single 5-beat frame
        @(negedge clk);
        len0 = 10'd5; len1 = 10'd3;
        set_s(1'b0, 1'b1, 32'h100, 1'b0);
        set_s(1'b1, 1'b1, 32'h300, 1'b0);
        #1;
        chk("idle_awvalid", awvalid, 0);
        do_write(12'h010, 32'd5, 0, 1);
        chk("owner_A", owner, 0);
        do_write(12'h000, 32'd1, 0, 1);
        send_x(1'b0, 5, 4, 4, 32'h100);
        set_s(1'b0, 1'b1, 32'h110, 1'b0);
        recv_y(1'b0, 5, 1'b0);
        do_poll(0, 32'h0, 32'h6);

        // Frame B: requester 1, len 3, source streams without tlast
        do_write(12'h010, 32'd3, 0, 1);
        chk("owner_B", owner, 1);
        do_write(12'h000, 32'd1, 0, 1);
        for (int i = 0; i < 8; i++) begin
            s1_tvalid = tbl[i].v; s1_tdata = tbl[i].d; s1_tlast = tbl[i].l;
            fir_ss_tready = tbl[i].rdy;
            #1;
            chk("tbl_ss_tvalid", fir_ss_tvalid, tbl[i].e_ssv);
            chk("tbl_ss_tlast", fir_ss_tlast, tbl[i].e_ssl);
            chk("tbl_s1_tready", s1_tready, tbl[i].e_str);
            chk("tbl_ss_tdata", fir_ss_tdata, tbl[i].d);
            chk("tbl_s0_tready", s0_tready, 0);
            @(negedge clk);
        end
        fir_ss_tready = 0;
        recv_y(1'b1, 3, 1'b0);
        do_poll(0, 32'h0, 32'h6);

        // Frame C: back to requester 0; write backpressure, early source tlast,
        // toggling Y ready, two not-done polls
        len0 = 10'd6; len1 = 10'd1;
        do_write(12'h010, 32'd6, 4, 1);
        chk("owner_C", owner, 0);
        chk("s1_stalled_C", s1_tready, 0);
        do_write(12'h000, 32'd1, 4, 1);
        send_x(1'b0, 3, 2, 2, 32'h110);
        set_s(1'b0, 1'b1, 32'h120, 1'b0);
        fir_ss_tready = 1;
        #1;
        chk("after_last_ss_tvalid", fir_ss_tvalid, 0);
        chk("after_last_s0_tready", s0_tready, 0);
        @(negedge clk);
        set_s(1'b0, 1'b0, 32'h0, 1'b0);
        fir_ss_tready = 0;
        recv_y(1'b0, 3, 1'b1);
        do_poll(2, 32'h0, 32'h6);

        // Frame D: requester 1 regranted alone; len 1 forces tlast on first beat
        chk("s1_stalled_D", s1_tready, 0);
        do_write(12'h010, 32'd1, 0, 1);
        chk("owner_D", owner, 1);
        do_write(12'h000, 32'd1, 0, 1);
        send_x(1'b1, 1, -1, 0, 32'h400);
        recv_y(1'b1, 1, 1'b0);
        do_poll(1, 32'h5, 32'h2);

        // Asynchronous reset in the middle of a requester 0 frame
        len0 = 10'd5;
        set_s(1'b0, 1'b1, 32'h500, 1'b0);
        do_write(12'h010, 32'd5, 0, 1);
        chk("owner_E", owner, 0);
        do_write(12'h000, 32'd1, 0, 1);
        fir_ss_tready = 1;
        #1;
        chk("pre_rst_s0_tready", s0_tready, 1);
        chk("pre_rst_busy", busy, 1);
        #1 rst = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_s0_tready", s0_tready, 0);
        chk("mid_rst_ss_tvalid", fir_ss_tvalid, 0);
        chk("mid_rst_awvalid", awvalid, 0);
        chk("mid_rst_owner", owner, 0);
        @(negedge clk);
        set_s(1'b0, 1'b0, 32'h0, 1'b0);
        fir_ss_tready = 0;
        rst = 0;
        @(negedge clk); #1;
        chk("post_rst_awvalid", awvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_frame_arbiter.md
# fir_frame_arbiter

Frame-level arbiter and sequencer that shares one `fir` engine between two AXI-Stream requesters. For each granted frame it programs `data_length` and `ap_start` over an AXI-Lite master port. It then routes the owner's X stream into the engine and the Y stream back to the owner, and polls `ap_done` before releasing the engine. It sits between the two requester stream pairs and the `fir` slave ports.

## Interface
- pADDR_WIDTH, 12, AXI-Lite address width
- pDATA_WIDTH, 32, stream and AXI-Lite data width
- pLEN_WIDTH, 10, frame length width (matches the `fir` data_length register)

- axis_clk  in  1  sole clock
- axis_rst  in  1  reset, asynchronous, active-high
- s0_tvalid/s0_tdata/s0_tlast  in  1/pDATA_WIDTH/1  requester 0 X stream; s0_tready  out  1
- s1_tvalid/s1_tdata/s1_tlast  in  1/pDATA_WIDTH/1  requester 1 X stream; s1_tready  out  1
- m0_tvalid/m0_tdata/m0_tlast  out  1/pDATA_WIDTH/1  requester 0 Y stream; m0_tready  in  1
- m1_tvalid/m1_tdata/m1_tlast  out  1/pDATA_WIDTH/1  requester 1 Y stream; m1_tready  in  1
- len0, len1  in  pLEN_WIDTH  frame length per requester, sampled at grant
- awvalid, wvalid  out  1  AXI-Lite write address/data valid
- awaddr  out  pADDR_WIDTH  write address
- wdata  out  pDATA_WIDTH  write data
- awready, wready  in  1  write ready
- arvalid  out  1  read address valid
- araddr  out  pADDR_WIDTH  read address
- arready  in  1  read address ready
- rvalid  in  1  read data valid
- rdata  in  pDATA_WIDTH  read data
- rready  out  1  read data ready
- fir_ss_tvalid/fir_ss_tdata/fir_ss_tlast  out  1/pDATA_WIDTH/1  X stream to the engine
- fir_ss_tready  in  1  engine X ready
- fir_sm_tvalid/fir_sm_tdata/fir_sm_tlast  in  1/pDATA_WIDTH/1  Y stream from the engine
- fir_sm_tready  out  1  engine Y ready
- busy  out  1  high in every state except IDLE
- owner  out  1  registered id of the granted requester

## Operation
- States and transitions:
  - IDLE: if s0_tvalid or s1_tvalid, go to WR_LEN.
  - WR_LEN: go to WR_START when (awready & wready).
  - WR_START: go to STREAM when (awready & wready).
  - STREAM: go to POLL when the Y beat with fir_sm_tlast completes its handshake.
  - POLL_AR: go to POLL_R when arready.
  - POLL_R: when rvalid, go to IDLE if rdata[1]=1, else go back to POLL_AR.
- Round-robin grant in IDLE:
  - Register last_grant; reset value is 1, so requester 0 wins the first tie.
  - If both requesters are valid, grant !last_grant. Otherwise grant the valid one.
  - At grant, latch owner, last_grant := owner, and len_q := len[owner]. Clear in_cnt and in_done.
- WR_LEN: awaddr=0x10, wdata=zero-extended len_q.
- WR_START: awaddr=0x00, wdata=1.
- Write rules: awvalid and wvalid rise together and are held, with address and data stable, until awready & wready are both high in the same cycle. They drop the next cycle.
- POLL_AR: arvalid=1, araddr=0x00, held until arready.
- POLL_R: rready=1; rdata is sampled when rvalid is high.
- STREAM input path (owner G):
  - fir_ss_tdata = sG_tdata.
  - fir_ss_tvalid = sG_tvalid & !in_done.
  - sG_tready = fir_ss_tready & !in_done.
  - fir_ss_tlast = sG_tlast | (len_q≠0 & in_cnt==len_q-1).
  - The non-owner's tready is 0.
  - Each X handshake increments in_cnt (pLEN_WIDTH bits). A handshake with fir_ss_tlast sets in_done.
- STREAM output path:
  - mG_tvalid/tdata/tlast = fir_sm_*, and fir_sm_tready = mG_tready.
  - The non-owner's m tvalid is 0.
- Outside STREAM, all stream valid and ready outputs are 0.
- len_q=0: length is not enforced; only the source tlast ends input.
- Source tlast arriving before len_q: the frame ends early. The engine output still ends on fir_sm_tlast.
- Source beats after the forced tlast stay stalled (tready=0) until the next grant of that requester.

## Timing
- Reset values: all valid and ready outputs 0, awaddr/araddr/wdata 0, busy 0, owner 0, state IDLE.
- axis_rst asserted mid-operation forces IDLE and all outputs to reset values immediately (asynchronous). There is no AXI-Lite completion after reset.
- Grant latency: request seen in IDLE at cycle t puts awvalid=1 at t+1.
- A write handshake at cycle t starts the next phase at t+1. There is a one-cycle gap between the two writes.
- Stream paths are combinational pass-through: zero added latency, with full throughput as permitted by the engine.
- The final Y handshake at t produces arvalid=1 at t+1.
- A done=0 read at t reissues arvalid at t+1.
- A done=1 read at t gives busy=0 at t+1. A new grant is possible at t+1, with awvalid at t+2.
- Simultaneous requests with one frame ending: the next grant uses last_grant updated at the previous grant.

## Test plan
- Reset: assert axis_rst mid-STREAM with s0 active -> within the same cycle busy=0, s0_tready=0, fir_ss_tvalid=0, awvalid=0.
- Single frame: s0 sends 5 beats (last with tlast), len0=5 -> writes (0x10,5) then (0x00,1), 5 X beats forwarded, 5 Y beats appear on m0 with m0_tlast on beat 5, poll ends on rdata=0x6.
- Round-robin: s0 and s1 valid at the same time after reset -> s0 granted first, s1 next, s0 after that. owner toggles 0,1,0.
- Forced tlast: len1=3, s1 streams 6 beats without tlast -> fir_ss_tlast on beat 3, and s1_tready=0 for beats 4-6 until the next grant.
- Backpressure: awready/wready delayed 4 cycles and m0_tready toggling -> awaddr/wdata stay stable, no beats lost, no duplicate beats.
- Poll retry: rdata=0x0 twice, then 0x6 -> three read transactions, busy falls one cycle after the third rvalid.
